// File: rtl/npu_wb_pkg.sv
// Shared types, widths and lane requantization for the NPE result write-back.
package npu_wb_pkg;

    localparam int LANE_OUT_W = 8;
    localparam int LANE_IN_W  = 2 * LANE_OUT_W;
    localparam int N_LANES    = 32;
    localparam int VEC_BITS   = N_LANES * LANE_IN_W;
    localparam int WORD_BITS  = N_LANES * LANE_OUT_W;
    localparam int SHIFT_W    = 4;
    localparam int CNT_W      = 16;
    localparam int EXT_W      = LANE_IN_W + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        (EXT_W'(1) <<< (LANE_OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } wb_state_e;

    // Round half up, arithmetic shift, saturate, optional relu.
    function automatic logic [LANE_OUT_W-1:0] requant(
        input logic [LANE_IN_W-1:0] lane,
        input logic [SHIFT_W-1:0]   shift,
        input logic                 relu
    );
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] rnd;
        logic signed [EXT_W-1:0] shr;
        logic [LANE_OUT_W-1:0]   res;
        ext = $signed({lane[LANE_IN_W-1], lane});
        rnd = ext;
        if (shift != '0) begin
            rnd = ext + $signed(EXT_W'(1) << (shift - SHIFT_W'(1)));
        end
        shr = rnd >>> shift;
        if (shr > SAT_MAX) begin
            res = SAT_MAX[LANE_OUT_W-1:0];
        end else if (shr < SAT_MIN) begin
            res = SAT_MIN[LANE_OUT_W-1:0];
        end else begin
            res = shr[LANE_OUT_W-1:0];
        end
        if (relu && res[LANE_OUT_W-1]) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/npe_result_fifo.sv
// Small synchronous FIFO holding whole result vectors.
module npe_result_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/npe_result_wb.sv
// Buffers NPE result vectors, requantizes or splits them, and writes
// the packed words to the output feature-map buffer.
module npe_result_wb
    import npu_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_cfg_start,
    input  logic [ADDR_WIDTH-1:0]             i_cfg_base_addr,
    input  logic [15:0]                       i_cfg_count,
    input  logic [3:0]                        i_cfg_shift,
    input  logic                              i_cfg_relu,
    input  logic                              i_cfg_raw,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_npe_result,
    input  logic                              i_npe_result_vld,
    output logic                              o_wr_en,
    output logic [ADDR_WIDTH-1:0]             o_wr_addr,
    output logic [DATA_COPIES*DATA_WIDTH-1:0] o_wr_data,
    input  logic                              i_wr_ready,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overflow
);

    localparam int LANE_IN = 2 * DATA_WIDTH;
    localparam int VEC_W   = DATA_COPIES * LANE_IN;
    localparam int WORD_W  = DATA_COPIES * DATA_WIDTH;

    wb_state_e state_q;
    wb_state_e state_d;

    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SHIFT_W-1:0]    shift_q;
    logic                  relu_q;
    logic                  raw_q;
    logic                  half_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WORD_W-1:0]     wr_data_q;
    logic                  overflow_q;

    logic              start_ok;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic              load;
    logic              xfer;
    logic              fifo_full;
    logic              fifo_empty;
    logic [VEC_W-1:0]  fifo_head;
    logic [WORD_W-1:0] norm_word;
    logic [WORD_W-1:0] raw_word;
    logic [WORD_W-1:0] next_word;

    npe_result_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .data  (i_npe_result),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // The output register refills in the same cycle it hands off a word.
    assign xfer = wr_en_q & i_wr_ready;
    assign load = !fifo_empty & (!wr_en_q | xfer);
    assign pop  = load & (!raw_q | half_q);
    assign push = accept & (!fifo_full | pop);
    assign drop = accept & fifo_full & !pop;

    always_comb begin
        norm_word = '0;
        for (int k = 0; k < DATA_COPIES; k++) begin
            norm_word[k*DATA_WIDTH +: DATA_WIDTH] =
                requant(fifo_head[k*LANE_IN +: LANE_IN], shift_q, relu_q);
        end
        raw_word  = half_q ? fifo_head[VEC_W-1 -: WORD_W]
                           : fifo_head[WORD_W-1:0];
        next_word = raw_q ? raw_word : norm_word;
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_cfg_start) begin
                    start_ok = 1'b1;
                    state_d  = (i_cfg_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_npe_result_vld) begin
                    accept = 1'b1;
                    if (cnt_q + CNT_W'(1) == count_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !wr_en_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            raw_q      <= 1'b0;
            half_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                wr_addr_q <= wr_addr_q + 1'b1;
            end
            if (load) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= next_word;
                half_q    <= raw_q & !half_q;
            end else if (xfer) begin
                wr_en_q <= 1'b0;
            end
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (start_ok) begin
                count_q    <= i_cfg_count;
                shift_q    <= i_cfg_shift;
                relu_q     <= i_cfg_relu;
                raw_q      <= i_cfg_raw;
                cnt_q      <= '0;
                half_q     <= 1'b0;
                overflow_q <= 1'b0;
                wr_addr_q  <= i_cfg_base_addr;
            end
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_overflow = overflow_q;
    assign o_busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_done     = (state_q == S_DONE);

endmodule
